// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues PC reads to synchronous imem and buffers {instr, pc} for decode.
// Optional same-cycle bypass of returning data when the queue is empty: define FETCH_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int IW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_in,
  input  logic          redirect,
  output logic          pc_stall,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [IW-1:0] instr_out,
  output logic [AW-1:0] instr_pc_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [IW-1:0] store_instr [DEPTH];
  logic [AW-1:0] store_pc    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          req_v;
  logic [AW-1:0] req_pc;

  logic [CW:0]   credits;
  logic          issue_ok;
  logic          head_v;
  logic          push;
  logic          pop;

  // An in-flight read already owns a slot, so it is counted as a credit.
  assign credits   = {1'b0, count} + {{CW{1'b0}}, req_v};
  assign issue_ok  = (credits < DEPTH_C);
  assign pc_stall  = ~issue_ok;
  assign imem_en   = issue_ok & ~redirect;
  assign imem_addr = pc_in;
  assign head_v    = (count != {CW{1'b0}});
  assign pop       = head_v & instr_ready & ~redirect;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass = ~head_v & req_v & ~redirect;
  // A bypassed entry that decode takes immediately is never written.
  assign push   = req_v & ~redirect & ~(bypass & instr_ready);

  // Head selection: storage first, then returning data when empty.
  always_comb begin
    instr_valid  = head_v | bypass;
    instr_out    = {IW{1'b0}};
    instr_pc_out = {AW{1'b0}};
    if (head_v) begin
      instr_out    = store_instr[rd_ptr];
      instr_pc_out = store_pc[rd_ptr];
    end else if (bypass) begin
      instr_out    = imem_data;
      instr_pc_out = req_pc;
    end else begin
      instr_out    = {IW{1'b0}};
      instr_pc_out = {AW{1'b0}};
    end
  end
`else
  assign push = req_v & ~redirect;

  // Head selection from storage only; zero when empty.
  always_comb begin
    instr_valid  = head_v;
    instr_out    = {IW{1'b0}};
    instr_pc_out = {AW{1'b0}};
    if (head_v) begin
      instr_out    = store_instr[rd_ptr];
      instr_pc_out = store_pc[rd_ptr];
    end else begin
      instr_out    = {IW{1'b0}};
      instr_pc_out = {AW{1'b0}};
    end
  end
`endif

  // Control state: in-flight stage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= {CW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      wr_ptr <= {PW{1'b0}};
      req_v  <= 1'b0;
      req_pc <= {AW{1'b0}};
    end else if (redirect) begin
      count  <= {CW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      wr_ptr <= {PW{1'b0}};
      req_v  <= 1'b0;
    end else begin
      req_v <= imem_en;
      if (imem_en) begin
        req_pc <= pc_in;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push & ~rst) begin
      store_instr[wr_ptr] <= imem_data;
      store_pc[wr_ptr]    <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build, no bypass): cycle table plus a wrap/ordering sequence.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW = 16;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect = 1'b0;
  logic [AW-1:0] pc_in = 16'h0;
  logic          pc_stall;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data = 16'h0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [IW-1:0] instr_out;
  logic [AW-1:0] instr_pc_out;

  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .redirect(redirect),
    .pc_stall(pc_stall), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc_out(instr_pc_out)
  );

  always #5 clk = ~clk;

  // Synchronous memory model: word at addr is 0xA000 + addr
  always @(posedge clk) if (imem_en) imem_data <= 16'hA000 + imem_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Credit rule must keep occupancy within DEPTH
  always @(negedge clk) if (started) check("no_overfill", 32'(dut.count <= 3'd4), 32'd1);

  typedef struct {
    logic        r, rd;
    logic [15:0] pc;
    logic        rdy, chk, v;
    logic [15:0] ins, ipc;
    logic        st, en;
  } vec_t;

  vec_t tbl [24];

  task automatic setv(input int i, input logic r, input logic rd, input logic [15:0] pc,
                      input logic rdy, input logic chk, input logic v, input logic [15:0] ins,
                      input logic [15:0] ipc, input logic st, input logic en);
    tbl[i] = '{r, rd, pc, rdy, chk, v, ins, ipc, st, en};
  endtask

  int mc, mr, pops;
  bit seen_pp3;
  logic [15:0] pcr;
  logic [15:0] q[$];
  logic [15:0] rpat;
  bit exp_en, pop_m;

  initial begin
    // reset, release
    setv(0,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    setv(1,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    setv(2,  1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    // streaming 0..3, head appears two cycles after issue
    setv(3,  1'b0, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    setv(4,  1'b0, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b1, 16'hA000, 16'h0000, 1'b0, 1'b1);
    setv(5,  1'b0, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b1, 16'hA001, 16'h0001, 1'b0, 1'b1);
    setv(6,  1'b0, 1'b0, 16'h0004, 1'b1, 1'b1, 1'b1, 16'hA002, 16'h0002, 1'b0, 1'b1);
    setv(7,  1'b0, 1'b0, 16'h0005, 1'b1, 1'b1, 1'b1, 16'hA003, 16'h0003, 1'b0, 1'b1);
    // backpressure: fill, stall, one pop, one issue, stall again
    setv(8,  1'b0, 1'b0, 16'h0006, 1'b0, 1'b1, 1'b1, 16'hA004, 16'h0004, 1'b0, 1'b1);
    setv(9,  1'b0, 1'b0, 16'h0007, 1'b0, 1'b1, 1'b1, 16'hA004, 16'h0004, 1'b0, 1'b1);
    setv(10, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b1, 1'b1, 16'hA004, 16'h0004, 1'b1, 1'b0);
    setv(11, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b1, 1'b1, 16'hA004, 16'h0004, 1'b1, 1'b0);
    setv(12, 1'b0, 1'b0, 16'h0008, 1'b1, 1'b1, 1'b1, 16'hA004, 16'h0004, 1'b1, 1'b0);
    setv(13, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b1, 1'b1, 16'hA005, 16'h0005, 1'b0, 1'b1);
    // redirect with count=3 and req_v=1; 0x0008 is squashed
    setv(14, 1'b0, 1'b1, 16'h0009, 1'b0, 1'b1, 1'b1, 16'hA005, 16'h0005, 1'b1, 1'b0);
    setv(15, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    setv(16, 1'b0, 1'b0, 16'h0041, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    setv(17, 1'b0, 1'b0, 16'h0042, 1'b1, 1'b1, 1'b1, 16'hA040, 16'h0040, 1'b0, 1'b1);
    setv(18, 1'b0, 1'b0, 16'h0043, 1'b1, 1'b1, 1'b1, 16'hA041, 16'h0041, 1'b0, 1'b1);
    // reach count=2 with req_v=1, then rst mid-operation
    setv(19, 1'b0, 1'b0, 16'h0044, 1'b0, 1'b1, 1'b1, 16'hA042, 16'h0042, 1'b0, 1'b1);
    setv(20, 1'b1, 1'b0, 16'h0045, 1'b0, 1'b1, 1'b1, 16'hA042, 16'h0042, 1'b0, 1'b1);
    setv(21, 1'b0, 1'b0, 16'h0080, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    setv(22, 1'b0, 1'b0, 16'h0081, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    setv(23, 1'b0, 1'b0, 16'h0082, 1'b1, 1'b1, 1'b1, 16'hA080, 16'h0080, 1'b0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      rst = tbl[i].r; redirect = tbl[i].rd; pc_in = tbl[i].pc; instr_ready = tbl[i].rdy;
      @(negedge clk);
      if (i == 2) started = 1'b1;
      if (tbl[i].chk) begin
        check($sformatf("c%0d instr_valid", i), 32'(instr_valid), 32'(tbl[i].v));
        check($sformatf("c%0d instr_out", i), 32'(instr_out), 32'(tbl[i].ins));
        check($sformatf("c%0d instr_pc_out", i), 32'(instr_pc_out), 32'(tbl[i].ipc));
        check($sformatf("c%0d pc_stall", i), 32'(pc_stall), 32'(tbl[i].st));
        check($sformatf("c%0d imem_en", i), 32'(imem_en), 32'(tbl[i].en));
      end
    end

    // Wrap/ordering: flush, then let a PC model run under a ready pattern
    @(posedge clk); #1;
    rst = 1'b0; redirect = 1'b1; instr_ready = 1'b0;
    @(negedge clk);
    mc = 0; mr = 0; pops = 0; seen_pp3 = 1'b0; pcr = 16'h0100;
    rpat = 16'b1011_0111_1111_0000;
    for (int k = 0; k < 80 && pops < 10; k++) begin
      @(posedge clk); #1;
      redirect = 1'b0; pc_in = pcr; instr_ready = rpat[k % 16];
      @(negedge clk);
      exp_en = ((mc + mr) < DEPTH);
      pop_m = (mc != 0) && instr_ready;
      check("wrap pc_stall", 32'(pc_stall), 32'(!exp_en));
      check("wrap imem_en", 32'(imem_en), 32'(exp_en));
      check("wrap instr_valid", 32'(instr_valid), 32'(mc != 0));
      if (exp_en) q.push_back(pcr);
      if (pop_m) begin
        if (q.size() > 0) begin
          check("wrap order pc", 32'(instr_pc_out), 32'(q[0]));
          check("wrap order instr", 32'(instr_out), 32'(16'hA000 + q[0]));
          void'(q.pop_front());
        end else begin
          check("wrap spurious pop", 32'd1, 32'd0);
        end
        pops++;
      end
      if (mc == 3 && mr == 1 && pop_m) seen_pp3 = 1'b1;
      mc = mc + mr - int'(pop_m);
      mr = int'(exp_en);
      if (exp_en) pcr = pcr + 16'h1;
    end
    check("wrap pops", 32'(pops), 32'd10);
    check("wrap push_pop_at_3", 32'(seen_pp3), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
